// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock elastic FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a
// selectable standard (registered) or first-word-fall-through read mode.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   w_en/data_in  write request and data (dropped while full)
//   r_en          read request / pop (ignored while empty)
//   clr_err       synchronous clear of overflow/underflow (a new error wins)
//   data_out      read data (registered in standard mode, head view in FWFT)
//   valid         data_out qualifier
//   full/empty    occupancy is DEPTH / 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter bit FWFT          = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     r_en,
  input  logic                     clr_err,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          w_acc, r_acc;

  // Flags come only from the registered pointers; the extra MSB is the wrap
  // bit that tells full (MSBs differ) apart from empty (pointers equal).
  always_comb begin
    full         = (w_ptr_q[AW] != r_ptr_q[AW]) &&
                   (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
    empty        = (w_ptr_q == r_ptr_q);
    count        = w_ptr_q - r_ptr_q;
    almost_full  = (count >= AF_T);
    almost_empty = (count <= AE_T);

    // No write-through on empty and no write-while-pop on full.
    w_acc   = w_en && !full;
    r_acc   = r_en && !empty;
    w_ptr_d = w_acc ? (w_ptr_q + PW'(1)) : w_ptr_q;
    r_ptr_d = r_acc ? (r_ptr_q + PW'(1)) : r_ptr_q;

    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d   = (w_en && full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d   = (r_en && empty) ? 1'b1 : (clr_err ? 1'b0 : unf_q);

    overflow  = ovf_q;
    underflow = unf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      mem[w_ptr_q[AW-1:0]] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is visible as soon as the pointers say non-empty; an empty
    // FIFO presents zero so the output matches its reset value.
    always_comb begin
      data_out = empty ? '0 : mem[r_ptr_q[AW-1:0]];
      valid    = !empty;
    end
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  vld_q, vld_d;

    // Registered read: data lands one edge after the accepted r_en, valid
    // pulses for that single cycle, and data_out otherwise holds.
    always_comb begin
      dout_d = r_acc ? mem[r_ptr_q[AW-1:0]] : dout_q;
      vld_d  = r_acc;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        dout_q <= dout_d;
        vld_q  <= vld_d;
      end
    end

    always_comb begin
      data_out = dout_q;
      valid    = vld_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  logic clk;
  logic reset;

  // Standard-mode instance (DEPTH=4, AF=3, AE=1)
  logic       s_w_en, s_r_en, s_clr;
  logic [7:0] s_data_in, s_data_out;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [2:0] s_count;

  // FWFT instance (same sizing)
  logic       f_w_en, f_r_en, f_clr;
  logic [7:0] f_data_in, f_data_out;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_count;

  int tests;
  int fails;

  // Reference models: plain queues of words plus sticky error bits.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] fq[$];
  bit m_ovf, m_unf, f_movf, f_munf;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3),
                    .AEMPTY_THRESH(1), .FWFT(1'b0)) u_std (
    .clk(clk), .reset(reset), .w_en(s_w_en), .data_in(s_data_in),
    .r_en(s_r_en), .clr_err(s_clr), .data_out(s_data_out), .valid(s_valid),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3),
                    .AEMPTY_THRESH(1), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .w_en(f_w_en), .data_in(f_data_in),
    .r_en(f_r_en), .clr_err(f_clr), .data_out(f_data_out), .valid(f_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the standard instance: every valid pulse pops one
  // expected word pushed when the read was issued.
  always @(negedge clk) begin
    if (reset && s_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL std_data: got %0h expected no valid word", s_data_out);
      end else begin
        chk("std_data", 32'(s_data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step_std(input bit we, input logic [7:0] din, input bit re, input bit clr);
    int  n;
    bit  racc;
    n    = mq.size();
    racc = re && (n > 0);
    s_w_en = we; s_data_in = din; s_r_en = re; s_clr = clr;
    if (racc) exp_q.push_back(mq.pop_front());
    if (we && n < 4) mq.push_back(din);
    m_ovf = (we && n == 4) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (re && n == 0) ? 1'b1 : (clr ? 1'b0 : m_unf);
    @(posedge clk);
    @(negedge clk);
    s_w_en = 1'b0; s_r_en = 1'b0; s_clr = 1'b0;
    n = mq.size();
    chk("std_count", 32'(s_count), 32'(n));
    chk("std_empty", 32'(s_empty), 32'(n == 0));
    chk("std_full",  32'(s_full),  32'(n == 4));
    chk("std_afull", 32'(s_af),    32'(n >= 3));
    chk("std_aempty",32'(s_ae),    32'(n <= 1));
    chk("std_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("std_unf",   32'(s_unf),   32'(m_unf));
    chk("std_valid", 32'(s_valid), 32'(racc));
  endtask

  task automatic step_fw(input bit we, input logic [7:0] din, input bit re, input bit clr);
    int n;
    n = fq.size();
    f_w_en = we; f_data_in = din; f_r_en = re; f_clr = clr;
    if (re && n > 0) void'(fq.pop_front());
    if (we && n < 4) fq.push_back(din);
    f_movf = (we && n == 4) ? 1'b1 : (clr ? 1'b0 : f_movf);
    f_munf = (re && n == 0) ? 1'b1 : (clr ? 1'b0 : f_munf);
    @(posedge clk);
    @(negedge clk);
    f_w_en = 1'b0; f_r_en = 1'b0; f_clr = 1'b0;
    n = fq.size();
    chk("fw_count", 32'(f_count), 32'(n));
    chk("fw_empty", 32'(f_empty), 32'(n == 0));
    chk("fw_full",  32'(f_full),  32'(n == 4));
    chk("fw_afull", 32'(f_af),    32'(n >= 3));
    chk("fw_aempty",32'(f_ae),    32'(n <= 1));
    chk("fw_ovf",   32'(f_ovf),   32'(f_movf));
    chk("fw_unf",   32'(f_unf),   32'(f_munf));
    chk("fw_valid", 32'(f_valid), 32'(n > 0));
    if (n > 0) chk("fw_head", 32'(f_data_out), 32'(fq[0]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_count"}, 32'(s_count), 32'd0);
    chk({tag, "_s_empty"}, 32'(s_empty), 32'd1);
    chk({tag, "_s_full"},  32'(s_full),  32'd0);
    chk({tag, "_s_ae"},    32'(s_ae),    32'd1);
    chk({tag, "_s_af"},    32'(s_af),    32'd0);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_s_dout"},  32'(s_data_out), 32'd0);
    chk({tag, "_s_ovf"},   32'(s_ovf),   32'd0);
    chk({tag, "_s_unf"},   32'(s_unf),   32'd0);
    chk({tag, "_f_count"}, 32'(f_count), 32'd0);
    chk({tag, "_f_empty"}, 32'(f_empty), 32'd1);
    chk({tag, "_f_valid"}, 32'(f_valid), 32'd0);
    chk({tag, "_f_dout"},  32'(f_data_out), 32'd0);
    chk({tag, "_f_ovf"},   32'(f_ovf),   32'd0);
    chk({tag, "_f_unf"},   32'(f_unf),   32'd0);
    mq.delete(); exp_q.delete(); fq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; f_movf = 1'b0; f_munf = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    reset = 1'b0;
    s_w_en = 0; s_r_en = 0; s_clr = 0; s_data_in = '0;
    f_w_en = 0; f_r_en = 0; f_clr = 0; f_data_in = '0;
    tests = 0; fails = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst_init");
    reset = 1'b1;

    // Reset asserted mid-stream, between edges.
    step_std(1, 8'h01, 0, 0);
    step_std(1, 8'h02, 0, 0);
    #3 reset = 1'b0;
    #1 chk_reset("rst_midstream");
    @(negedge clk);
    reset = 1'b1;

    // Fill: count 1..4 with threshold flags checked each step.
    for (int i = 0; i < 4; i++) step_std(1, 8'hA1 + 8'(i), 0, 0);

    // Overflow: 0xEE must be dropped and the flag must stick.
    step_std(1, 8'hEE, 0, 0);
    step_std(0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step_std(0, 8'h00, 1, 0);
    step_std(0, 8'h00, 0, 1);

    // Underflow with a simultaneous write into the empty FIFO.
    step_std(1, 8'h55, 1, 0);
    step_std(0, 8'h00, 1, 0);
    step_std(0, 8'h00, 0, 1);

    // Wrap stress at count=2.
    d = 8'h00;
    for (int i = 0; i < 2; i++) begin step_std(1, d, 0, 0); d++; end
    for (int i = 0; i < 40; i++) begin step_std(1, d, 1, 0); d++; end
    for (int i = 0; i < 2; i++) step_std(0, 8'h00, 1, 0);

    // Random traffic, including error flags and clear collisions.
    for (int i = 0; i < 300; i++)
      step_std(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));

    // Reset while count=3 and a read is being driven.
    while (mq.size() > 0) step_std(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step_std(1, 8'hC0 + 8'(i), 0, 0);
    step_std(0, 8'h00, 1, 0);
    chk("pre_rst_count", 32'(s_count), 32'd3);
    s_r_en = 1'b1;
    #2 reset = 1'b0;
    #1 chk_reset("rst_midop");
    @(negedge clk);
    s_r_en = 1'b0;
    reset = 1'b1;
    step_std(1, 8'h77, 0, 0);
    step_std(0, 8'h00, 1, 0);
    step_std(0, 8'h00, 0, 0);

    // FWFT directed sequence.
    step_fw(1, 8'h10, 0, 0);
    chk("fw_first", 32'(f_data_out), 32'h10);
    step_fw(1, 8'h20, 0, 0);
    step_fw(0, 8'h00, 1, 0);
    chk("fw_second", 32'(f_data_out), 32'h20);
    step_fw(0, 8'h00, 1, 0);
    for (int i = 0; i < 200; i++)
      step_fw(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    #3 reset = 1'b0;
    #1 chk_reset("rst_final");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk("std_scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
